// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix framebuffer fetch stage.
// Build option: MATRIX_FB_DOUBLE_BUFFER_EN selects the banked (11-bit) framebuffer address.
package matrix_pkg;

  localparam int unsigned MATRIX_COLUMNS   = 64;
  localparam int unsigned MATRIX_ROWS_HALF = 16;
  localparam int unsigned PIXEL_DEPTH      = 6;
  localparam int unsigned PIXEL_WIDTH      = 3 * PIXEL_DEPTH;

  localparam int unsigned COL_WIDTH = $clog2(MATRIX_COLUMNS);
  localparam int unsigned ROW_WIDTH = $clog2(MATRIX_ROWS_HALF);

  // Colour field offsets inside one 18-bit pixel {R, G, B}.
  localparam int unsigned R_OFFSET = 12;
  localparam int unsigned G_OFFSET = 6;
  localparam int unsigned B_OFFSET = 0;

  // The first bit plane of a frame is the MSB plane.
  localparam logic [PIXEL_DEPTH-1:0] FIRST_PLANE_MASK = 6'b100000;

`ifdef MATRIX_FB_DOUBLE_BUFFER_EN
  localparam int unsigned FB_ADDR_WIDTH = 11;
`else
  localparam int unsigned FB_ADDR_WIDTH = 10;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/matrix_plane_slice.sv
// Combinational bit-plane slice: one 18-bit pixel plus plane mask gives one {R,G,B} bit triple.
module matrix_plane_slice
  import matrix_pkg::*;
(
  input  logic [PIXEL_WIDTH-1:0] pixel,
  input  logic [PIXEL_DEPTH-1:0] mask,
  output logic [2:0]             rgb
);

  // A multi-bit mask ORs every selected plane; an all-zero mask yields black.
  always_comb begin
    rgb = {|(pixel[R_OFFSET +: PIXEL_DEPTH] & mask),
           |(pixel[G_OFFSET +: PIXEL_DEPTH] & mask),
           |(pixel[B_OFFSET +: PIXEL_DEPTH] & mask)};
  end

endmodule

// File: rtl/matrix_pixel_fetch.sv
// Framebuffer read stage: issues one RAM read per pixel-load cycle, slices the
// selected brightness plane one cycle later, detects frame starts and swaps banks.
// Build option: MATRIX_FB_DOUBLE_BUFFER_EN enables the front/back bank swap.
module matrix_pixel_fetch
  import matrix_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 36
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   pixel_load_en,
  input  logic [COL_WIDTH-1:0]   column_address,
  input  logic [ROW_WIDTH-1:0]   row_address,
  input  logic [PIXEL_DEPTH-1:0] brightness_mask,
  output logic                   ram_rd_en,
  output logic [ADDR_WIDTH-1:0]  ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]  ram_rd_data,
  output logic [2:0]             rgb_top,
  output logic [2:0]             rgb_bottom,
  output logic                   rgb_valid,
  output logic                   frame_start,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   bank_display
);

  fetch_state_e state_q, state_d;

  logic [PIXEL_DEPTH-1:0] mask_q;
  logic                   valid_q;
  logic                   frame_start_q;
  logic                   frame_rise;
  logic [2:0]             top_slice;
  logic [2:0]             bottom_slice;

  // A frame begins on a load rising edge that targets row 0 on the MSB plane.
  // Reset suppresses it so a reset cycle can never start a frame or take a swap.
  always_comb begin
    frame_rise = pixel_load_en && (state_q != StFetch) && (row_address == '0) &&
                 (brightness_mask == FIRST_PLANE_MASK) && !reset;
  end

`ifdef MATRIX_FB_DOUBLE_BUFFER_EN
  logic bank_q;
  logic swap_take;
  logic swap_ack_q;

  // The swap is applied combinationally so the frame's first read already hits the new bank.
  always_comb begin
    swap_take    = frame_rise && swap_req;
    bank_display = bank_q ^ swap_take;
    swap_ack     = swap_ack_q;
    ram_rd_addr  = {bank_display, row_address, column_address};
  end

  // Bank and acknowledge registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      bank_q     <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      bank_q     <= bank_display;
      swap_ack_q <= swap_take;
    end
  end
`else
  logic unused_swap_req;

  // Single bank: no swap path, address is just {row, column}.
  always_comb begin
    unused_swap_req = swap_req;
    bank_display    = 1'b0;
    swap_ack        = 1'b0;
    ram_rd_addr     = {row_address, column_address};
  end
`endif

  // The RAM strobe follows the load enable directly.
  always_comb begin
    ram_rd_en = pixel_load_en;
  end

  // Fetch FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pixel_load_en) state_d = StFetch;
      StFetch: if (!pixel_load_en) state_d = StDrain;
      StDrain: state_d = pixel_load_en ? StFetch : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, plane mask and valid pipeline registers (aligned with the RAM's one-cycle latency).
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= brightness_mask;
      valid_q       <= pixel_load_en;
      frame_start_q <= frame_rise;
    end
  end

  matrix_plane_slice u_slice_top (
    .pixel (ram_rd_data[PIXEL_WIDTH-1:0]),
    .mask  (mask_q),
    .rgb   (top_slice)
  );

  matrix_plane_slice u_slice_bottom (
    .pixel (ram_rd_data[2*PIXEL_WIDTH-1:PIXEL_WIDTH]),
    .mask  (mask_q),
    .rgb   (bottom_slice)
  );

  // Data lines are black whenever no fetched pixel is in flight.
  always_comb begin
    rgb_top     = valid_q ? top_slice : 3'b000;
    rgb_bottom  = valid_q ? bottom_slice : 3'b000;
    rgb_valid   = valid_q;
    frame_start = frame_start_q;
  end

endmodule

// File: doc/matrix_pixel_fetch.md
# matrix_pixel_fetch

Framebuffer read stage directly downstream of the matrix scan block. It consumes the scan block's column/row address, brightness mask and pixel-load enable, and reads the 36-bit pixel pair (top half row r, bottom half row r+16) from a synchronous framebuffer RAM. It bit-slices the current brightness plane and presents the six RGB data lines in the cycle the scan block asserts its pixel clock. It also owns frame-boundary detection and front/back bank swapping for the host writer.

## Interface
Parameters:
- ADDR_WIDTH, 10: RAM word address width, {row[3:0], column[5:0]} (11 with double buffer).
- DATA_WIDTH, 36: RAM word; [35:18] bottom pixel, [17:0] top pixel; each pixel {R[5:0],G[5:0],B[5:0]}.

Ports:
- clk_in  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- pixel_load_en  in  1  level enable from scan block; one pixel fetched per high cycle.
- column_address  in  6  column being loaded.
- row_address  in  4  row being loaded.
- brightness_mask  in  6  one-hot bit-plane select.
- ram_rd_en  out  1  RAM read strobe.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM data, valid one cycle after ram_rd_en.
- rgb_top  out  3  {R,G,B} for top half.
- rgb_bottom  out  3  {R,G,B} for bottom half.
- rgb_valid  out  1  rgb_* hold a fetched pixel.
- frame_start  out  1  one-cycle pulse at first fetch of a frame.
- swap_req  in  1  host requests bank swap (level, held until ack).
- swap_ack  out  1  one-cycle pulse when swap taken.
- bank_display  out  1  bank currently displayed.

## Operation
- ram_rd_en = pixel_load_en; ram_rd_addr = {bank_display, row_address, column_address} (bank bit only with double buffer). Both are combinational.
- Sample at cycle N: register mask_q <= brightness_mask and valid_q <= pixel_load_en.
- Cycle N+1 outputs:
  - rgb_top = {|(R_top & mask_q), |(G_top & mask_q), |(B_top & mask_q)}; same slicing for rgb_bottom.
  - rgb_* are forced 000 when valid_q = 0.
  - mask_q = 0 gives 000. A non-one-hot mask ORs the selected bits; it is not an error.
- FSM states:
  - IDLE: pixel_load_en=0.
  - FETCH: pixel_load_en=1.
  - DRAIN: one cycle after the last fetch; the data phase completes here.
  - Transitions:
    - IDLE->FETCH when pixel_load_en rises.
    - FETCH->DRAIN when pixel_load_en falls.
    - DRAIN->FETCH if pixel_load_en is high again, else ->IDLE.
- Frame start is a rising pixel_load_en with row_address=0 and brightness_mask=6'b100000. It pulses frame_start in cycle N+1.
- Swap: at a frame start with swap_req=1, bank_display toggles before the address is formed. The first read of the frame therefore uses the new bank, and swap_ack pulses in the same cycle as frame_start.
- A swap_req that goes high mid-frame waits for the next frame start.
- Column count is not checked. Any number of consecutive load cycles is accepted, and column_address wrap (63->0) needs no special handling.

## Timing
- Read latency 1. rgb_*/rgb_valid are valid exactly in cycle N+1, aligned with the scan block's pixel clock (pixel_load_en delayed one cycle).
- Back-to-back loads give a continuous stream with no bubbles.
- Reset values: rgb_top=0, rgb_bottom=0, rgb_valid=0, frame_start=0, swap_ack=0, bank_display=0, ram_rd_en follows pixel_load_en, FSM=IDLE, mask_q=0.
- Reset mid-FETCH: the following cycle shows rgb_valid=0; any pending swap is dropped (bank_display=0).
- reset and frame start in the same cycle: reset wins.

## Configuration
- MATRIX_FB_DOUBLE_BUFFER_EN defined:
  - ADDR_WIDTH is 11 with the bank bit as MSB.
  - swap logic active as above.
- Undefined:
  - ADDR_WIDTH is 10.
  - bank_display tied 0.
  - swap_ack tied 0; swap_req ignored.
  - frame_start is still generated.

## Structure
- Shared package matrix_pkg:
  - MATRIX_COLUMNS=64, MATRIX_ROWS_HALF=16, PIXEL_DEPTH=6.
  - pixel field offsets R/G/B within the 18-bit pixel.
  - fetch FSM state encoding.
- One sub-module, matrix_plane_slice: combinational 18-bit pixel + mask -> 3-bit RGB. Instantiated twice (top, bottom).

## Test plan
- RAM word at {row 3, col 10} = top R=6'h20, bottom B=6'h01. Load with mask 100000, then 000001. Expect rgb_top=100/rgb_bottom=000 on the first fetch, and rgb_top=000/rgb_bottom=001 on the second, each in cycle N+1.
- 64 consecutive load cycles, columns 63->0, data = column index in R_top. Expect 64 contiguous rgb_valid cycles, correct bit per column, no gaps. rgb forced 0 after the DRAIN cycle.
- brightness_mask=0 with nonzero data -> rgb_*=000 while rgb_valid=1.
- Double buffer: swap_req asserted mid-frame. Expect no toggle until the load with row 0/mask 100000. Then bank_display=1, ram_rd_addr[10]=1 on that first read, and swap_ack coincident with frame_start.
- Reset asserted during FETCH with swap pending. Next cycle: rgb_valid=0, bank_display=0, swap_ack=0, FSM IDLE.
- Macro undefined: swap_req held high across two frame starts -> bank_display stays 0, swap_ack never pulses, frame_start pulses twice.
